wishbone_ram_target: RTL and testbench

Pipelined Wishbone B4 target (responder) fronting a synchronous, byte-enabled word RAM. It is the far end of the initiator-to-target path that the skid buffer feeds: it accepts one request per cycle, returns ACK or ERR in order after a fixed latency, and throttles the initiator with STALL when too many responses are outstanding. It serves as the default on-chip memory target and as the reference responder in bus testbenches.

---
 rtl/wishbone_pkg.sv | 31 +++
 rtl/wishbone_ram_array.sv | 38 +++
 rtl/wishbone_ram_target.sv | 129 ++++++++++++
 tb/tb_wishbone_ram_target.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone B4 definitions: cycle/burst type encodings, SEL width helper
// and the per-stage record carried by target response pipelines.
package wishbone_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC    = 3'b000,
    CTI_CONST_ADDR = 3'b001,
    CTI_INCR       = 3'b010,
    CTI_END        = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  // One slot of a response pipeline: occupied, error response, write access.
  typedef struct packed {
    logic valid;
    logic err;
    logic we;
  } resp_stage_t;

  // Number of SEL lanes for a given data bus and lane granularity.
  function automatic int sel_width(input int data_width, input int granularity);
    return data_width / granularity;
  endfunction

endpackage

// File: rtl/wishbone_ram_array.sv
// Single-port synchronous RAM with per-lane write enables and a registered
// read port. Written in the plain style synthesis maps onto block RAM.
module wishbone_ram_array
  import wishbone_pkg::*;
#(
  parameter int Depth       = 1024,
  parameter int DataWidth   = 32,
  parameter int Granularity = 8
) (
  input  logic                                           clk,
  input  logic                                           en,
  input  logic                                           we,
  input  logic [sel_width(DataWidth, Granularity)-1:0]   sel,
  input  logic [$clog2(Depth)-1:0]                       addr,
  input  logic [DataWidth-1:0]                           wdata,
  output logic [DataWidth-1:0]                           rdata
);

  localparam int Lanes = sel_width(DataWidth, Granularity);

  logic [DataWidth-1:0] mem [Depth];

  // Lane-masked write or registered read, one access per enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int l = 0; l < Lanes; l++) begin
          if (sel[l]) begin
            mem[addr][l*Granularity +: Granularity] <= wdata[l*Granularity +: Granularity];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wishbone_ram_target.sv
// Pipelined Wishbone B4 target in front of a byte-enabled word RAM. Requests
// are accepted one per cycle, answered in order after a fixed latency, and
// throttled with STALL once the outstanding-response limit is reached.
module wishbone_ram_target
  import wishbone_pkg::*;
#(
  parameter int AddressWidth   = 16,
  parameter int DataWidth      = 32,
  parameter int Granularity    = 8,
  parameter int Depth          = 1024,
  parameter int ReadLatency    = 2,
  parameter int MaxOutstanding = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         cyc,
  input  logic                                         stb,
  input  logic                                         we,
  input  logic [AddressWidth-1:0]                      addr,
  input  logic [DataWidth-1:0]                         dat_to_target,
  input  logic [sel_width(DataWidth, Granularity)-1:0] sel,
  input  logic                                         lock,
  input  logic [3:0]                                   tga,
  input  logic [3:0]                                   tgc,
  input  logic [3:0]                                   tgd_to_target,
  input  logic [2:0]                                   cti,
  input  logic [1:0]                                   bte,
  output logic                                         stall,
  output logic                                         ack,
  output logic                                         err,
  output logic                                         rty,
  output logic [DataWidth-1:0]                         dat_to_initiator,
  output logic [3:0]                                   tgd_to_initiator
);

  localparam int IndexWidth = $clog2(Depth);
  localparam int CountWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MaxOutstanding);

  logic                  accept;
  logic                  in_range;
  logic                  resp;
  logic [IndexWidth-1:0] index;
  logic [CountWidth-1:0] count;
  logic [DataWidth-1:0]  ram_rdata;
  logic [DataWidth-1:0]  rd_last;
  resp_stage_t           pipe [ReadLatency];
  resp_stage_t           last;

  // Sideband and burst hints carry no meaning for a single-beat RAM target.
  logic unused_inputs;
  assign unused_inputs = ^{lock, tga, tgc, tgd_to_target, cti, bte};

  assign in_range = (addr >> IndexWidth) == '0;
  assign index    = addr[IndexWidth-1:0];
  assign accept   = cyc & stb & ~stall;

  assign last  = pipe[ReadLatency-1];
  assign ack   = last.valid & ~last.err & cyc;
  assign err   = last.valid & last.err & cyc;
  assign resp  = ack | err;
  // Depends only on count and the last stage, so STB never loops into STALL.
  assign stall = (count == MaxCount) & ~resp;

  assign rty              = 1'b0;
  assign tgd_to_initiator = 4'b0000;
  assign dat_to_initiator = (ack & ~last.we) ? rd_last : '0;

  wishbone_ram_array #(
    .Depth       (Depth),
    .DataWidth   (DataWidth),
    .Granularity (Granularity)
  ) u_ram (
    .clk   (clk),
    .en    (accept & in_range),
    .we    (we),
    .sel   (sel),
    .addr  (index),
    .wdata (dat_to_target),
    .rdata (ram_rdata)
  );

  // RAM output register is the first latency stage; extra stages just delay it.
  generate
    if (ReadLatency == 1) begin : g_no_delay
      assign rd_last = ram_rdata;
    end else begin : g_delay
      logic [DataWidth-1:0] dly [ReadLatency-1];

      // Shift read data alongside the response pipeline.
      always_ff @(posedge clk) begin
        dly[0] <= ram_rdata;
        for (int i = 1; i < ReadLatency - 1; i++) begin
          dly[i] <= dly[i-1];
        end
      end

      assign rd_last = dly[ReadLatency-2];
    end
  endgenerate

  // Response pipeline: loaded at accept, shifts every cycle, flushed when CYC drops.
  always_ff @(posedge clk) begin
    if (rst || !cyc) begin
      for (int i = 0; i < ReadLatency; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: accept, err: ~in_range, we: we};
      for (int i = 1; i < ReadLatency; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Outstanding-response counter: up on accept, down on a response.
  always_ff @(posedge clk) begin
    if (rst || !cyc) begin
      count <= '0;
    end else if (accept && !resp) begin
      count <= count + CountWidth'(1);
    end else if (!accept && resp) begin
      count <= count - CountWidth'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: tb/tb_wishbone_ram_target.sv
// Self-checking bench for wishbone_ram_target: a table of request vectors with
// hand-computed expected responses feeds a scoreboard queue, plus hand-written
// sequences for stall throttling, CYC drop and mid-transaction reset.
module tb_wishbone_ram_target;

  typedef struct {
    logic        stb;
    logic        we;
    logic [15:0] addr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;

  // Default instance: ReadLatency 2, MaxOutstanding 2
  logic        cyc0, stb0, we0;
  logic [15:0] addr0;
  logic [31:0] wdat0, dat0;
  logic [3:0]  sel0;
  logic        stall0, ack0, err0, unused_rty0;
  logic [3:0]  unused_tgd0;

  // Throttled instance: ReadLatency 2, MaxOutstanding 1
  logic        cyc1, stb1, we1;
  logic [15:0] addr1;
  logic [31:0] unused_dat1;
  logic        stall1, ack1, err1, unused_rty1;
  logic [3:0]  unused_tgd1;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc_no = 0;
  logic cur_err;
  logic [31:0] cur_dat;
  logic s0_stall, s0_ack, s0_err;
  logic [31:0] s0_dat;
  logic s1_stall, s1_ack, s1_err;
  exp_t q0 [$];
  vec_t tbl [$];

  wishbone_ram_target dut0 (
    .clk(clk), .rst(rst), .cyc(cyc0), .stb(stb0), .we(we0), .addr(addr0),
    .dat_to_target(wdat0), .sel(sel0), .lock(1'b0), .tga(4'b0000), .tgc(4'b0000),
    .tgd_to_target(4'b0000), .cti(3'b000), .bte(2'b00),
    .stall(stall0), .ack(ack0), .err(err0), .rty(unused_rty0),
    .dat_to_initiator(dat0), .tgd_to_initiator(unused_tgd0)
  );

  wishbone_ram_target #(.ReadLatency(2), .MaxOutstanding(1)) dut1 (
    .clk(clk), .rst(rst), .cyc(cyc1), .stb(stb1), .we(we1), .addr(addr1),
    .dat_to_target(32'h0000_0000), .sel(4'b1111), .lock(1'b0), .tga(4'b0000),
    .tgc(4'b0000), .tgd_to_target(4'b0000), .cti(3'b000), .bte(2'b00),
    .stall(stall1), .ack(ack1), .err(err1), .rty(unused_rty1),
    .dat_to_initiator(unused_dat1), .tgd_to_initiator(unused_tgd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t wr(logic [15:0] a, logic [31:0] d, logic [3:0] s, logic e);
    vec_t v;
    v = '{stb: 1'b1, we: 1'b1, addr: a, dat: d, sel: s, exp_err: e, exp_dat: 32'h0};
    return v;
  endfunction

  function automatic vec_t rd(logic [15:0] a, logic [31:0] d, logic e);
    vec_t v;
    v = '{stb: 1'b1, we: 1'b0, addr: a, dat: 32'h0, sel: 4'b1111, exp_err: e, exp_dat: d};
    return v;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v = '{stb: 1'b0, we: 1'b0, addr: 16'h0, dat: 32'h0, sel: 4'b0000, exp_err: 1'b0, exp_dat: 32'h0};
    return v;
  endfunction

  task automatic fail(string name, logic [63:0] got, logic [63:0] want);
    n_miss++;
    $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  task automatic drive(vec_t v);
    cyc0    = 1'b1;
    stb0    = v.stb;
    we0     = v.we;
    addr0   = v.addr;
    wdat0   = v.dat;
    sel0    = v.sel;
    cur_err = v.exp_err;
    cur_dat = v.exp_dat;
  endtask

  // One clock: sample and score at the falling edge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    s0_stall = stall0; s0_ack = ack0; s0_err = err0; s0_dat = dat0;
    s1_stall = stall1; s1_ack = ack1; s1_err = err1;
    if (ack0 | err0) begin
      n_vec++;
      if (q0.size() == 0) begin
        fail($sformatf("unexpected_resp@%0d", cyc_no), {30'h0, ack0, err0, dat0}, 64'h0);
      end else begin
        e = q0.pop_front();
        if (ack0 !== ~e.err || err0 !== e.err || dat0 !== e.dat || cyc_no != e.cyc + 2)
          fail($sformatf("resp@%0d_exp@%0d", cyc_no, e.cyc + 2),
               {30'h0, ack0, err0, dat0}, {30'h0, ~e.err, e.err, e.dat});
      end
    end else if (dat0 !== 32'h0) begin
      n_vec++;
      fail($sformatf("idle_dat@%0d", cyc_no), {32'h0, dat0}, 64'h0);
    end
    if (cyc0 & stb0) begin
      n_vec++;
      if (stall0 !== 1'b0) fail("stall0", {63'h0, stall0}, 64'h0);
      else q0.push_back('{err: cur_err, dat: cur_dat, cyc: cyc_no});
    end
    @(posedge clk);
    cyc_no++;
    #1;
  endtask

  initial begin
    int n_acc;
    rst = 1'b1;
    drive(idle()); cyc0 = 1'b0;
    cyc1 = 1'b0; stb1 = 1'b0; we1 = 1'b0; addr1 = 16'h0;
    cur_err = 1'b0; cur_dat = 32'h0;
    repeat (3) step();
    rst = 1'b0;

    // Idle after reset: nothing asserted, including with CYC high and STB low.
    for (int i = 0; i < 10; i++) begin
      if (i >= 6) begin cyc0 = 1'b1; cyc1 = 1'b1; end
      step();
      n_vec++;
      if ({s0_stall, s0_ack, s0_err, s1_stall, s1_ack, s1_err} !== 6'b0 || s0_dat !== 32'h0)
        fail($sformatf("reset_idle%0d", i), {26'h0, s0_stall, s0_ack, s0_err, s1_stall, s1_ack, s1_err, s0_dat}, 64'h0);
    end
    cyc1 = 1'b0;

    // Vector table with hand-computed expectations.
    tbl.push_back(wr(16'd5, 32'hDEAD_BEEF, 4'b1111, 1'b0));
    tbl.push_back(wr(16'd5, 32'h0000_AA00, 4'b0010, 1'b0));
    tbl.push_back(rd(16'd5, 32'hDEAD_AAEF, 1'b0));
    tbl.push_back(idle());
    for (int i = 0; i < 8; i++)
      tbl.push_back(wr(16'd16 + 16'(i), 32'hA500_0000 | (32'(i) * 32'h0001_0101), 4'b1111, 1'b0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(rd(16'd16 + 16'(i), 32'hA500_0000 | (32'(i) * 32'h0001_0101), 1'b0));
    tbl.push_back(rd(16'd5, 32'hDEAD_AAEF, 1'b0));
    tbl.push_back(rd(16'd1024, 32'h0, 1'b1));
    tbl.push_back(rd(16'd16, 32'hA500_0000, 1'b0));
    tbl.push_back(wr(16'd1029, 32'hFFFF_FFFF, 4'b1111, 1'b1));
    tbl.push_back(rd(16'd5, 32'hDEAD_AAEF, 1'b0));
    tbl.push_back(wr(16'd5, 32'h0000_0000, 4'b0000, 1'b0));
    tbl.push_back(rd(16'd5, 32'hDEAD_AAEF, 1'b0));
    tbl.push_back(wr(16'd40, 32'hCAFE_F00D, 4'b1111, 1'b0));
    tbl.push_back(rd(16'd40, 32'hCAFE_F00D, 1'b0));
    tbl.push_back(wr(16'd41, 32'h1122_3344, 4'b1111, 1'b0));
    tbl.push_back(wr(16'd41, 32'h5566_7788, 4'b1001, 1'b0));
    tbl.push_back(rd(16'd41, 32'h5522_3388, 1'b0));
    tbl.push_back(rd(16'hFFFF, 32'h0, 1'b1));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      step();
    end
    drive(idle());
    repeat (4) step();

    // CYC dropped with two reads in flight: their responses must vanish.
    drive(wr(16'd60, 32'h1234_5678, 4'b1111, 1'b0)); step();
    drive(rd(16'd5, 32'hDEAD_AAEF, 1'b0)); step();
    drive(rd(16'd16, 32'hA500_0000, 1'b0)); step();
    drive(idle()); cyc0 = 1'b0; q0.delete(); step();
    drive(rd(16'd60, 32'h1234_5678, 1'b0)); step();
    drive(idle());
    repeat (4) step();

    // Reset with a read in flight: no response afterwards, RAM keeps prior writes.
    drive(rd(16'd40, 32'hCAFE_F00D, 1'b0)); step();
    drive(idle()); cyc0 = 1'b0; rst = 1'b1; q0.delete(); step();
    rst = 1'b0; cyc0 = 1'b1;
    repeat (3) step();
    drive(rd(16'd60, 32'h1234_5678, 1'b0)); step();
    drive(idle());
    repeat (4) step();

    // MaxOutstanding 1: four held reads give STALL 0,1,0,1 and ACKs every other cycle.
    n_acc = 0;
    cyc1 = 1'b1; stb1 = 1'b1; we1 = 1'b0; addr1 = 16'd0;
    for (int t = 0; t < 10; t++) begin
      step();
      n_vec++;
      if (s1_stall !== ((t % 2 == 1) && t <= 7) ||
          s1_ack !== ((t % 2 == 0) && t >= 2 && t <= 8) || s1_err !== 1'b0)
        fail($sformatf("throttle_t%0d", t), {61'h0, s1_stall, s1_ack, s1_err},
             {61'h0, 1'((t % 2 == 1) && t <= 7), 1'((t % 2 == 0) && t >= 2 && t <= 8), 1'b0});
      if (stb1 && !s1_stall) begin
        n_acc++;
        addr1 = addr1 + 16'd1;
        if (n_acc == 4) stb1 = 1'b0;
      end
    end

    // MaxOutstanding 1: CYC drop clears the count, so STALL releases with no ACK.
    addr1 = 16'd0; stb1 = 1'b1; step();
    n_vec++;
    if (s1_stall !== 1'b0) fail("drop_accept_stall", {63'h0, s1_stall}, 64'h0);
    cyc1 = 1'b0; stb1 = 1'b0; step();
    n_vec++;
    if (s1_stall !== 1'b1) fail("drop_full_stall", {63'h0, s1_stall}, 64'h1);
    cyc1 = 1'b1;
    for (int t = 0; t < 2; t++) begin
      step();
      n_vec++;
      if ({s1_stall, s1_ack, s1_err} !== 3'b000)
        fail($sformatf("drop_after%0d", t), {61'h0, s1_stall, s1_ack, s1_err}, 64'h0);
    end
    cyc1 = 1'b0;

    n_vec++;
    if (q0.size() != 0) fail("pending_responses", 64'(q0.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
